pc_ctrl: RTL
============

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, which sets the program counter width in bits.
REQ-002 The block SHALL have parameter LUT_AW, default 5, which sets the branch-target table index width (32 entries).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin or restart program execution.
REQ-006 The block SHALL have port stall, input, 1 bit: hold the PC this cycle.
REQ-007 The block SHALL have port halt, input, 1 bit: the current instruction is a halt.
REQ-008 The block SHALL have port branch_en, input, 1 bit: the current instruction is a conditional branch.
REQ-009 The block SHALL have port eq, input, 1 bit: the ALU branch condition; branch taken when 1.
REQ-010 The block SHALL have port lut_idx, input, LUT_AW bits: the branch-target table index.
REQ-011 The block SHALL have port prog_ctr, output, PC_W bits: the registered program counter (instruction fetch address).
REQ-012 The block SHALL have port running, output, 1 bit: high while in state RUN.
REQ-013 The block SHALL have port done, output, 1 bit: high while in state DONE.
REQ-014 The block SHALL have port cycle_ct, output, 16 bits: the count of cycles spent in RUN.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; running and done SHALL be decoded from registered state only.
REQ-016 In IDLE, prog_ctr SHALL hold 0, and start=1 SHALL move the FSM to RUN on the next edge with prog_ctr=0 and cycle_ct=0.
REQ-017 In RUN, per-cycle priority SHALL be stall > halt > taken branch > increment.
REQ-018 When stall=1 in RUN, prog_ctr SHALL hold.
REQ-019 When halt=1 and stall=0 in RUN, prog_ctr SHALL hold and the FSM SHALL enter DONE, so done rises the cycle after halt is sampled.
REQ-020 When branch_en=1 and eq=1 in RUN, prog_ctr SHALL load the branch target.
REQ-021 When branch_en=1 and eq=0 in RUN, or when branch_en=0, prog_ctr SHALL increment by 1.
REQ-022 All PC arithmetic SHALL wrap modulo 2^PC_W (maximum value + 1 -> 0).
REQ-023 cycle_ct SHALL increment on every RUN cycle, including stall cycles and the halt cycle, and SHALL saturate at 16'hFFFF.
REQ-024 In RUN, start SHALL be ignored.
REQ-025 In DONE, prog_ctr and cycle_ct SHALL hold; start=1 SHALL restart as from IDLE (REQ-016).
REQ-026 Inputs halt, branch_en, eq, lut_idx and stall SHALL be ignored outside RUN.

Reset
REQ-027 reset=1 SHALL override all inputs in any state, including mid-run.
REQ-028 On reset, state SHALL be IDLE, prog_ctr=0, cycle_ct=0, running=0 and done=0, all on the same edge.

Configuration
REQ-029 With macro PC_RELATIVE_BRANCH_EN defined, the branch target SHALL be prog_ctr plus the table entry read as a signed PC_W-bit offset, wrapping.
REQ-030 With PC_RELATIVE_BRANCH_EN undefined, the branch target SHALL be the table entry used as an absolute address.

Structure
REQ-031 A shared package pc_pkg SHALL hold PC_W, LUT_AW, the FSM state enum and the 32-entry target table constant.
REQ-032 The target table SHALL define entry 3 = 10'h028 and entry 5 = 10'h3FC; all other entries SHALL be 0.
REQ-033 One combinational sub-module, branch_lut (lut_idx -> entry), SHALL hold the table; the FSM, PC and counter SHALL live in pc_ctrl.

Verification
REQ-034 Scenario reset/start: reset 2 cycles, then start pulse -> running=1 next cycle, prog_ctr=0, then 1, 2, 3 on successive cycles.
REQ-035 Scenario taken branch: at prog_ctr=7, branch_en=1, eq=1, lut_idx=3 -> next prog_ctr=0x028 (absolute) or 0x02F (relative); with eq=0 -> 8.
REQ-036 Scenario relative negative: PC_RELATIVE_BRANCH_EN defined, prog_ctr=2, lut_idx=5, taken -> prog_ctr wraps to 0x3FE.
REQ-037 Scenario stall/halt priority: stall=1 and halt=1 at prog_ctr=4 -> holds 4 and stays in RUN; next cycle stall=0, halt=1 -> done=1 next cycle, prog_ctr=4, cycle_ct frozen.
REQ-038 Scenario wrap/restart: increment from 0x3FF -> 0x000; reset mid-run -> IDLE, all outputs 0; start from DONE -> prog_ctr=0, cycle_ct=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller: default widths,
// FSM state encoding and the constant branch-target table.
package pc_pkg;

  localparam int PC_W      = 10;
  localparam int LUT_AW    = 5;
  localparam int LUT_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Branch targets indexed by lut_idx; unlisted entries resolve to 0.
  localparam logic [PC_W-1:0] BRANCH_TABLE [LUT_DEPTH] = '{
    3:       10'h028,
    5:       10'h3FC,
    default: 10'h000
  };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: maps a table index to its stored entry,
// resized to the program-counter width.
module branch_lut #(
  parameter int LUT_AW = pc_pkg::LUT_AW,
  parameter int W      = pc_pkg::PC_W
) (
  input  logic [LUT_AW-1:0] lut_idx,
  output logic [W-1:0]      entry
);
  import pc_pkg::*;

  assign entry = W'(BRANCH_TABLE[lut_idx]);

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: IDLE/RUN/DONE sequencer with stall, halt and
// table-driven branches. Define PC_RELATIVE_BRANCH_EN for PC-relative targets.
module pc_ctrl #(
  parameter int PC_W   = pc_pkg::PC_W,
  parameter int LUT_AW = pc_pkg::LUT_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_en,
  input  logic              eq,
  input  logic [LUT_AW-1:0] lut_idx,
  output logic [PC_W-1:0]   prog_ctr,
  output logic              running,
  output logic              done,
  output logic [15:0]       cycle_ct
);
  import pc_pkg::*;

  state_e           state;
  logic [PC_W-1:0]  lut_entry;
  logic [PC_W-1:0]  branch_target;

  branch_lut #(
    .LUT_AW (LUT_AW),
    .W      (PC_W)
  ) u_branch_lut (
    .lut_idx (lut_idx),
    .entry   (lut_entry)
  );

`ifdef PC_RELATIVE_BRANCH_EN
  // The entry is a two's-complement offset; plain addition wraps modulo 2^PC_W.
  assign branch_target = prog_ctr + lut_entry;
`else
  assign branch_target = lut_entry;
`endif

  assign running = (state == RUN);
  assign done    = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      cycle_ct <= '0;
    end else begin
      case (state)
        IDLE: begin
          prog_ctr <= '0;
          if (start) begin
            state    <= RUN;
            cycle_ct <= '0;
          end
        end
        RUN: begin
          // Counts stall and halt cycles too, saturating rather than wrapping.
          if (cycle_ct != 16'hFFFF) cycle_ct <= cycle_ct + 16'd1;
          if (!stall) begin
            if (halt)                 state    <= DONE;
            else if (branch_en && eq) prog_ctr <= branch_target;
            else                      prog_ctr <= prog_ctr + PC_W'(1);
          end
        end
        DONE: begin
          if (start) begin
            state    <= RUN;
            prog_ctr <= '0;
            cycle_ct <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          prog_ctr <= '0;
          cycle_ct <= '0;
        end
      endcase
    end
  end

endmodule
